// File: rtl/fn_to_rec_fn_pkg.sv
// Shared types and constants for the IEEE-to-recoded float converter.
// Holds the sequencer state, input classification and recoded exponent class codes.
package fn_to_rec_fn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } convState_t;

    typedef enum logic [2:0] {
        CLASS_NORMAL,
        CLASS_SUBNORMAL,
        CLASS_ZERO,
        CLASS_INF,
        CLASS_NAN
    } fnClass_t;

    // Top three bits of the recoded exponent for the special classes.
    localparam logic [2:0] REC_ZERO = 3'b000;
    localparam logic [2:0] REC_INF  = 3'b110;
    localparam logic [2:0] REC_NAN  = 3'b111;

    function automatic logic [31:0] recBias(input int unsigned expWidth);
        return 32'd1 << (expWidth - 1);
    endfunction

endpackage

// File: rtl/rec_fn_pack.sv
// Combinational packer: classified sign/exp/fract (plus subnormal shift count) -> recoded word.
// Zero latency; no flow control, output follows inputs.
module rec_fn_pack
    import fn_to_rec_fn_pkg::*;
#(
    parameter int expWidth  = 8,
    parameter int sigWidth  = 24,
    parameter int distWidth = $clog2(sigWidth)
) (
    input  logic                       sign,
    input  fnClass_t                   fnClass,
    input  logic [expWidth-1:0]        exp,
    input  logic [distWidth-1:0]       normDist,
    input  logic [sigWidth-2:0]        fract,
    output logic [expWidth+sigWidth:0] recWord
);

    localparam int recWidth = expWidth + 1;
    localparam logic [expWidth:0] BIAS    = recWidth'(recBias(expWidth));
    localparam logic [expWidth:0] EXP_ONE = recWidth'(1);
    localparam logic [expWidth:0] EXP_TWO = recWidth'(2);

    logic [expWidth:0]   recExp;
    logic [sigWidth-2:0] recFract;
    logic [expWidth:0]   distExt;

    assign distExt = recWidth'(normDist);

    always_comb begin
        recExp   = '0;
        recFract = '0;
        case (fnClass)
            CLASS_NORMAL: begin
                recExp   = {1'b0, exp} + BIAS + EXP_ONE;
                recFract = fract;
            end
            CLASS_SUBNORMAL: begin
                // fract arrives normalised (MSB set); the MSB becomes the hidden bit.
                recExp   = (distExt ^ {recWidth{1'b1}}) + BIAS + EXP_TWO;
                recFract = {fract[sigWidth-3:0], 1'b0};
            end
            CLASS_ZERO: begin
                recExp   = {REC_ZERO, {(expWidth-2){1'b0}}};
            end
            CLASS_INF: begin
                recExp   = {REC_INF, {(expWidth-2){1'b0}}};
            end
            CLASS_NAN: begin
                recExp   = {REC_NAN, {(expWidth-2){1'b0}}};
                recFract = fract;
            end
            default: begin
                recExp   = '0;
                recFract = '0;
            end
        endcase
    end

    assign recWord = {sign, recExp, recFract};

endmodule

// File: rtl/fn_to_rec_fn_seq.sv
// Go/done IEEE-to-recoded converter; 1 cycle for normal/special, normDist+2 for subnormals.
// go is only sampled in IDLE; no stall on the output, done is a one-cycle pulse with out held after.
module fn_to_rec_fn_seq
    import fn_to_rec_fn_pkg::*;
#(
    parameter int expWidth = 8,
    parameter int sigWidth = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic [expWidth+sigWidth-1:0] in_,
    output logic [expWidth+sigWidth:0]   out,
    output logic                         done
);

    localparam int distWidth = $clog2(sigWidth);

    convState_t            state;
    logic                  signReg;
    logic [expWidth-1:0]   expReg;
    logic [sigWidth-2:0]   fractReg;
    logic [distWidth-1:0]  normDist;

    logic                  inSign;
    logic [expWidth-1:0]   inExp;
    logic [sigWidth-2:0]   inFract;
    fnClass_t              inClass;

    logic                  packSign;
    fnClass_t              packClass;
    logic [expWidth-1:0]   packExp;
    logic [distWidth-1:0]  packDist;
    logic [sigWidth-2:0]   packFract;
    logic [expWidth+sigWidth:0] packWord;

    assign inSign  = in_[expWidth+sigWidth-1];
    assign inExp   = in_[expWidth+sigWidth-2 -: expWidth];
    assign inFract = in_[sigWidth-2:0];

    always_comb begin
        inClass = CLASS_NORMAL;
        if (inExp == '1) begin
            inClass = (inFract == '0) ? CLASS_INF : CLASS_NAN;
        end else if (inExp == '0) begin
            inClass = (inFract == '0) ? CLASS_ZERO : CLASS_SUBNORMAL;
        end
    end

    // The packer serves the IDLE fast path from the live input and the NORM exit from the registers.
    always_comb begin
        packSign  = inSign;
        packClass = inClass;
        packExp   = inExp;
        packDist  = '0;
        packFract = inFract;
        if (state == NORM) begin
            packSign  = signReg;
            packClass = CLASS_SUBNORMAL;
            packExp   = expReg;
            packDist  = normDist;
            packFract = fractReg;
        end
    end

    rec_fn_pack #(
        .expWidth  (expWidth),
        .sigWidth  (sigWidth),
        .distWidth (distWidth)
    ) u_pack (
        .sign     (packSign),
        .fnClass  (packClass),
        .exp      (packExp),
        .normDist (packDist),
        .fract    (packFract),
        .recWord  (packWord)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out      <= '0;
            done     <= 1'b0;
            signReg  <= 1'b0;
            expReg   <= '0;
            fractReg <= '0;
            normDist <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        signReg  <= inSign;
                        expReg   <= inExp;
                        fractReg <= inFract;
                        normDist <= '0;
                        if (inClass == CLASS_SUBNORMAL) begin
                            state <= NORM;
                        end else begin
                            out   <= packWord;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                NORM: begin
                    if (fractReg[sigWidth-2]) begin
                        out   <= packWord;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        fractReg <= fractReg << 1;
                        normDist <= normDist + distWidth'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
